phase_sweep_ctrl: RTL and testbench
===================================

// Module: phase_sweep_ctrl
// PURPOSE
//  Sequencer directly upstream of the dynamic-PLL phase stepper. Issues a programmed number
//  of single phase steps (change_phase/cntsel/updn) and waits for each step's done to re-assert.
//  Holds a settle interval after each step, then pulses step_valid with the step index so the
//  TDC calibration logic can sample at each phase.
// PARAMETERS
//  STEP_W      8       width of num_steps and step_idx (max 255 steps per sweep)
//  CNTSEL      5'b00001 counter select driven to the phase stepper (1/8 shift, fixed per build)
//  SETTLE_CYC  16      scanclk cycles held after each step's done before step_valid (>=1)
//  TIMEOUT_CYC 4096    cycles allowed per step in WAIT_LOW+WAIT_DONE (timeout build only)
// PORTS
//  scanclk      in   1       single clock, same clock as the phase stepper
//  rst          in   1       synchronous, active-high reset
//  start        in   1       one-cycle request; sampled only in IDLE
//  num_steps    in   STEP_W  steps in the sweep; latched on accepted start
//  dir_in       in   1       1=positive, 0=negative shift; latched on accepted start
//  abort        in   1       stop the sweep; highest priority after rst
//  dpll_done    in   1       done level from the phase stepper
//  change_phase out  1       one-cycle pulse that restarts the stepper
//  cntsel_out   out  5       = CNTSEL while busy, 0 otherwise
//  updn_out     out  1       latched dir_in while busy, 0 otherwise
//  busy         out  1       high in every state except IDLE
//  step_valid   out  1       one-cycle pulse, phase settled for step_idx
//  step_idx     out  STEP_W  1-based index of the current step; holds last value after sweep
//  sweep_done   out  1       one-cycle pulse at normal end of sweep
//  timeout_err  out  1       sticky error flag (timeout build only; tied 0 otherwise)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, internal counters 0. All outputs registered.
//  States: IDLE, REQ, WAIT_LOW, WAIT_DONE, SETTLE, REPORT, FIN, ERR.
//  IDLE: start & num_steps!=0 -> REQ; latch num_steps/dir_in; step_idx<=0; clear timeout_err.
//        start & num_steps==0 -> FIN (sweep_done one cycle after start, no change_phase).
//  REQ: change_phase=1 for exactly this cycle; step_idx<=step_idx+1; -> WAIT_LOW.
//  WAIT_LOW: wait for dpll_done==0 (stepper left its stale done state) -> WAIT_DONE.
//  WAIT_DONE: wait for dpll_done==1 -> SETTLE; settle counter loaded with SETTLE_CYC-1.
//  SETTLE: count down to 0 -> REPORT. REPORT: step_valid=1 for one cycle;
//        step_idx==num_steps -> FIN, else -> REQ. Min step period = SETTLE_CYC+4 cycles.
//  FIN: sweep_done=1 for one cycle -> IDLE. busy drops in the cycle after FIN.
//  start while busy: ignored, no queuing. dpll_done glitch high in WAIT_LOW: ignored.
//  abort: any non-IDLE state -> IDLE next cycle; no step_valid/sweep_done for the partial
//        step; change_phase never asserted in the abort cycle or after. step_idx keeps value.
//  rst and abort in the same cycle: rst wins (identical outcome except step_idx cleared).
//  step_idx counts 1..num_steps, no wrap: num_steps=255 ends at 255 with STEP_W=8.
// CONFIGURATION
//  PHASE_SWEEP_TIMEOUT_EN defined: per-step counter cleared in REQ, counts in WAIT_LOW and
//   WAIT_DONE; reaching TIMEOUT_CYC -> ERR: timeout_err<=1 (sticky until next accepted start
//   or rst), ERR -> IDLE next cycle, no sweep_done. Undefined: no counter, waits indefinitely,
//   timeout_err tied 0, ERR unreachable.
// STRUCTURE
//  Package tdc_clk_pkg: state enum, CNTSEL_EIGHTH=5'b00001, UP=1'b1/DN=1'b0 constants.
//  Single flat module; settle and timeout counters inline, no sub-module.
// TESTING
//  Stepper model: dpll_done drops 1 cycle after change_phase, re-rises after 20 cycles.
//  num_steps=3, dir=1 -> 3 change_phase pulses, step_valid with step_idx 1,2,3, updn_out=1,
//   cntsel_out=5'b00001 while busy, sweep_done once; step period = 20+SETTLE_CYC+~4 cycles.
//  num_steps=0 -> sweep_done exactly 1 cycle after start, no change_phase, busy 1 cycle.
//  abort during SETTLE of step 2 -> IDLE next cycle, no step_valid for step 2, no sweep_done;
//   new start then runs a full sweep from step_idx 1.
//  start pulsed mid-sweep and dpll_done high pulse during WAIT_LOW -> both ignored.
//  Timeout build, TIMEOUT_CYC=64, model never re-raises done -> timeout_err=1 at cycle 64
//   of the wait, busy=0, no sweep_done; next start clears timeout_err.
//  rst asserted in WAIT_DONE -> all outputs 0 in the following cycle.

Source files
------------

// File: rtl/tdc_clk_pkg.sv
// tdc_clk_pkg: shared state encoding and constants for the TDC clocking blocks
package tdc_clk_pkg;
   typedef enum logic [2:0] {IDLE, REQ, WAIT_LOW, WAIT_DONE, SETTLE, REPORT, FIN, ERR} sweep_state_e;
   localparam logic [4:0] CNTSEL_EIGHTH = 5'b00001;
   localparam logic UP = 1'b1;
   localparam logic DN = 1'b0;
endpackage

// File: rtl/phase_sweep_ctrl.sv
// phase_sweep_ctrl: sequences dynamic-PLL phase steps for TDC calibration; PHASE_SWEEP_TIMEOUT_EN adds a per-step timeout
module phase_sweep_ctrl
   import tdc_clk_pkg::*;
#(
   parameter int unsigned STEP_W     = 8,
   parameter logic [4:0]  CNTSEL     = CNTSEL_EIGHTH,
   parameter int unsigned SETTLE_CYC = 16
`ifdef PHASE_SWEEP_TIMEOUT_EN
   , parameter int unsigned TIMEOUT_CYC = 4096
`endif
) (
   input  logic              scanclk,
   input  logic              rst,
   input  logic              start,
   input  logic [STEP_W-1:0] num_steps,
   input  logic              dir_in,
   input  logic              abort,
   input  logic              dpll_done,
   output logic              change_phase,
   output logic [4:0]        cntsel_out,
   output logic              updn_out,
   output logic              busy,
   output logic              step_valid,
   output logic [STEP_W-1:0] step_idx,
   output logic              sweep_done,
   output logic              timeout_err
);
   localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
   sweep_state_e state_q, state_d;
   logic [STEP_W-1:0] num_q, num_d, idx_q, idx_d;
   logic dir_q, dir_d;
   logic [SW-1:0] set_q, set_d;
   logic change_phase_q, busy_q, step_valid_q, sweep_done_q, updn_q;
   logic [4:0] cntsel_q;
`ifdef PHASE_SWEEP_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] to_q, to_d;
   logic err_q, err_d;
`endif

   always_comb begin
      state_d = state_q;
      num_d   = num_q;
      dir_d   = dir_q;
      idx_d   = idx_q;
      set_d   = set_q;
`ifdef PHASE_SWEEP_TIMEOUT_EN
      to_d    = to_q;
      err_d   = err_q;
`endif
      case (state_q)
         IDLE: if (start) begin
            num_d   = num_steps;
            dir_d   = dir_in;
            idx_d   = num_steps != '0 ? '0 : idx_q;
            state_d = num_steps != '0 ? REQ : FIN;
`ifdef PHASE_SWEEP_TIMEOUT_EN
            err_d   = 1'b0;
`endif
         end
         REQ: begin
            idx_d   = idx_q + 1'b1;
            state_d = WAIT_LOW;
`ifdef PHASE_SWEEP_TIMEOUT_EN
            to_d    = '0;
`endif
         end
         // a stale done still high here must not count as completion
         WAIT_LOW:  state_d = dpll_done ? WAIT_LOW : WAIT_DONE;
         WAIT_DONE: if (dpll_done) begin
            state_d = SETTLE;
            set_d   = SW'(SETTLE_CYC - 1);
         end
         SETTLE: begin
            state_d = set_q == '0 ? REPORT : SETTLE;
            set_d   = set_q - 1'b1;
         end
         REPORT:  state_d = idx_q == num_q ? FIN : REQ;
         default: state_d = IDLE;
      endcase
`ifdef PHASE_SWEEP_TIMEOUT_EN
      if (state_q == WAIT_LOW || state_q == WAIT_DONE) begin
         to_d = to_q + 1'b1;
         if (to_q == TW'(TIMEOUT_CYC - 1)) state_d = ERR;
      end
`endif
      if (abort && state_q != IDLE) state_d = IDLE;
`ifdef PHASE_SWEEP_TIMEOUT_EN
      if (state_d == ERR) err_d = 1'b1;
`endif
   end

   always_ff @(posedge scanclk) begin
      if (rst) begin
         state_q        <= IDLE;
         num_q          <= '0;
         dir_q          <= 1'b0;
         idx_q          <= '0;
         set_q          <= '0;
         change_phase_q <= 1'b0;
         busy_q         <= 1'b0;
         step_valid_q   <= 1'b0;
         sweep_done_q   <= 1'b0;
         updn_q         <= DN;
         cntsel_q       <= '0;
      end else begin
         state_q        <= state_d;
         num_q          <= num_d;
         dir_q          <= dir_d;
         idx_q          <= idx_d;
         set_q          <= set_d;
         change_phase_q <= state_d == REQ;
         busy_q         <= state_d != IDLE;
         step_valid_q   <= state_d == REPORT;
         sweep_done_q   <= state_d == FIN;
         updn_q         <= state_d != IDLE ? dir_d : DN;
         cntsel_q       <= state_d != IDLE ? CNTSEL : '0;
      end
   end

`ifdef PHASE_SWEEP_TIMEOUT_EN
   always_ff @(posedge scanclk) begin
      if (rst) begin
         to_q  <= '0;
         err_q <= 1'b0;
      end else begin
         to_q  <= to_d;
         err_q <= err_d;
      end
   end
   assign timeout_err = err_q;
`else
   assign timeout_err = 1'b0;
`endif

   assign change_phase = change_phase_q;
   assign cntsel_out   = cntsel_q;
   assign updn_out     = updn_q;
   assign busy         = busy_q;
   assign step_valid   = step_valid_q;
   assign step_idx     = idx_q;
   assign sweep_done   = sweep_done_q;
endmodule

// File: tb/tb_phase_sweep_ctrl.sv
// tb_phase_sweep_ctrl: randomized sweeps against a stepper model with a scoreboard of expected step/sweep events
module tb_phase_sweep_ctrl;
   localparam int SETTLE = 16;
   localparam int LOW    = 20;

   logic       scanclk = 1'b0, rst = 1'b1, start = 1'b0, dir_in = 1'b0, abort = 1'b0, dpll_done;
   logic [7:0] num_steps = '0, step_idx;
   logic [4:0] cntsel_out;
   logic       change_phase, updn_out, busy, step_valid, sweep_done, timeout_err;

   phase_sweep_ctrl #(
      .STEP_W(8), .CNTSEL(5'b00001), .SETTLE_CYC(SETTLE)
`ifdef PHASE_SWEEP_TIMEOUT_EN
      , .TIMEOUT_CYC(64)
`endif
   ) dut (
      .scanclk(scanclk), .rst(rst), .start(start), .num_steps(num_steps), .dir_in(dir_in),
      .abort(abort), .dpll_done(dpll_done), .change_phase(change_phase), .cntsel_out(cntsel_out),
      .updn_out(updn_out), .busy(busy), .step_valid(step_valid), .step_idx(step_idx),
      .sweep_done(sweep_done), .timeout_err(timeout_err)
   );

   always #5 scanclk = ~scanclk;

   typedef struct {bit done; int idx; bit from_start;} exp_t;
   exp_t q[$];
   int checks = 0, failures = 0;
   int cyc = 0, last_cp = 0, last_sv = 0, start_cyc = 0, cp_cnt = 0;
   int dly = 0;
   bit never_rise = 1'b0;
   bit exp_dir = 1'b0;
   int st_cnt = -1;

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge scanclk) cyc <= cyc + 1;

   // stepper: done drops dly+1 cycles after change_phase and is low for LOW cycles
   always @(posedge scanclk) begin
      if (change_phase) st_cnt <= 0;
      else if (st_cnt >= 0) st_cnt <= st_cnt + 1;
   end
   assign dpll_done = !(st_cnt >= dly && (never_rise || st_cnt < dly + LOW));

   always @(negedge scanclk) if (!rst) begin
      exp_t e;
      if (change_phase) begin
         cp_cnt++;
         last_cp = cyc;
      end
      chk("cntsel_out", int'(cntsel_out), busy ? 1 : 0);
      chk("updn_out", int'(updn_out), busy ? int'(exp_dir) : 0);
`ifndef PHASE_SWEEP_TIMEOUT_EN
      chk("timeout_err_tied", int'(timeout_err), 0);
`endif
      if (step_valid || sweep_done) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: step_valid=%0d sweep_done=%0d idx=%0d with nothing expected (cycle %0d)",
                     step_valid, sweep_done, step_idx, cyc);
         end else begin
            e = q.pop_front();
            chk("event_kind_done", int'(sweep_done), int'(e.done));
            chk("event_kind_valid", int'(step_valid), int'(!e.done));
            if (step_valid && !e.done) begin
               chk("step_idx", int'(step_idx), e.idx);
               chk("step_latency", cyc - last_cp, 2 + dly + LOW + SETTLE);
               last_sv = cyc;
            end else if (sweep_done && e.done) begin
               chk("done_latency", cyc - (e.from_start ? start_cyc : last_sv), 1);
            end
         end
      end
   end

   task automatic issue(int n, bit dir);
      @(posedge scanclk); #1;
      start = 1'b1; num_steps = 8'(n); dir_in = dir;
      exp_dir = dir; start_cyc = cyc; cp_cnt = 0;
      for (int i = 1; i <= n; i++) q.push_back('{1'b0, i, 1'b0});
      q.push_back('{1'b1, 0, n == 0});
      @(posedge scanclk); #1;
      start = 1'b0;
   endtask

   task automatic wait_drain(int limit);
      int k = 0;
      while ((q.size() != 0 || busy) && k < limit) begin
         @(posedge scanclk); #1;
         k++;
      end
      chk("drain_in_time", int'(k < limit), 1);
   endtask

   task automatic wait_cp(int n);
      int k = 0;
      while (cp_cnt < n && k < 400) begin
         @(posedge scanclk);
         k++;
      end
      chk("change_phase_seen", int'(cp_cnt >= n), 1);
   endtask

   initial begin
      int n;
      bit d;
      repeat (3) @(posedge scanclk);
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_step_idx", int'(step_idx), 0);
      chk("rst_outs", int'({change_phase, step_valid, sweep_done, updn_out, timeout_err, cntsel_out}), 0);
      rst = 1'b0;

      issue(0, 1'b1);
      chk("zero_no_cp", cp_cnt, 0);
      @(posedge scanclk); #1;
      chk("zero_busy_one_cycle", int'(busy), 0);
      wait_drain(10);

      issue(3, 1'b1);
      wait_drain(300);
      chk("cp_count_3", cp_cnt, 3);

      for (int it = 0; it < 6; it++) begin
         dly = $urandom_range(0, 3);
         n = $urandom_range(1, 5);
         d = 1'($urandom_range(0, 1));
         issue(n, d);
         if (it == 2) begin
            repeat ($urandom_range(5, 60)) @(posedge scanclk);
            #1 start = 1'b1; num_steps = 8'd7; dir_in = !d;
            @(posedge scanclk); #1 start = 1'b0;
         end
         wait_drain(n * 60 + 100);
         chk("cp_count_rand", cp_cnt, n);
      end
      dly = 0;

      issue(3, 1'b0);
      wait_cp(2);
      repeat (25) @(posedge scanclk);
      #1 abort = 1'b1;
      q.delete();
      @(posedge scanclk); #1 abort = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_step_idx", int'(step_idx), 2);
      chk("abort_no_cp", int'(change_phase), 0);
      repeat (60) @(posedge scanclk);
      #1 chk("abort_cp_total", cp_cnt, 2);
      issue(3, 1'b1);
      wait_drain(300);
      chk("after_abort_cp", cp_cnt, 3);

      issue(2, 1'b0);
      wait_cp(1);
      repeat (4) @(posedge scanclk);
      #1 rst = 1'b1;
      q.delete();
      @(posedge scanclk); #1 rst = 1'b0;
      chk("rst_wd_busy", int'(busy), 0);
      chk("rst_wd_step_idx", int'(step_idx), 0);
      chk("rst_wd_outs", int'({change_phase, step_valid, sweep_done, updn_out, timeout_err, cntsel_out}), 0);
      repeat (40) @(posedge scanclk);

`ifdef PHASE_SWEEP_TIMEOUT_EN
      never_rise = 1'b1;
      issue(2, 1'b1);
      q.delete();
      wait_cp(1);
      begin
         int k = 0;
         while (!timeout_err && k < 80) begin
            @(posedge scanclk); #1;
            k++;
         end
         chk("timeout_latency", k, 64);
      end
      @(posedge scanclk); #1;
      chk("timeout_busy", int'(busy), 0);
      repeat (20) @(posedge scanclk);
      #1 chk("timeout_sticky", int'(timeout_err), 1);
      never_rise = 1'b0;
      issue(1, 1'b0);
      chk("timeout_cleared", int'(timeout_err), 0);
      wait_drain(200);
`endif

      issue(255, 1'b1);
      wait_drain(255 * 45);
      chk("cp_count_255", cp_cnt, 255);
      chk("final_idx_255", int'(step_idx), 255);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
